ssd1306_spi_arbiter: RTL and testbench
======================================

# ssd1306_spi_arbiter

Arbiter between two byte-level requesters and the single SSD1306 SPI byte shift register. Port 0 carries command traffic from the init sequencer; port 1 carries command/data traffic from the frame renderer. The block grants the shift register per burst, locks it until the byte flagged last completes, and drives chip-select and D/C. It also releases a stalled burst owner after a programmable idle timeout.

## Interface
Parameters:
- RR_MODE, 0: 0 = fixed priority (port 0 wins); 1 = round-robin (port not granted last wins on contention)
- TIMEOUT_CYCLES, 4096: locked-idle cycles before forced release; 0 disables timeout
- CNT_WIDTH, 16: width of burst byte counter

Ports:
- clk_in  in  1  system clock; all logic on rising edge
- resetn_in  in  1  asynchronous, active-low reset
- reqN_start_in (N=0,1)  in  1  level request; held until reqN_ready_out falls
- reqN_byte_in  in  8  byte to send, sampled at accept
- reqN_last_in  in  1  byte ends burst, sampled at accept
- reqN_dc_in  in  1  D/C level for byte (0 cmd, 1 data), sampled at accept
- reqN_ready_out  out  1  low only while this port's accepted byte is in flight
- sr_start_out  out  1  start to shift register
- sr_byte_out  out  8  latched byte
- sr_ready_in  in  1  shift register idle; falls after start taken, rises when byte shifted
- oled_dc_out  out  1  latched D/C of current byte
- oled_csn_out  out  1  low while a burst owner exists
- grant_out  out  2  one-hot current owner; 0 when unowned
- busy_out  out  1  state != S_IDLE
- timeout_out  out  1  one-cycle pulse on forced release
- byte_count_out  out  CNT_WIDTH  bytes completed in current/most recent burst

## Operation
- Reset values: reqN_ready_out=1, sr_start_out=0, sr_byte_out=0, oled_dc_out=0, oled_csn_out=1, grant_out=0, busy_out=0, timeout_out=0, byte_count_out=0; state S_IDLE; RR pointer = port 1 last (port 0 wins first contention).
- States: S_IDLE (no owner), S_LOCKED (owner held, waiting next byte), S_SEND, S_WAIT.
- S_IDLE: if sr_ready_in and any start, select winner (fixed or RR), latch byte/dc/last, owner=winner, byte_count=0, csn=0, clear winner's ready -> S_SEND.
- S_LOCKED: only owner's start considered; accept as above without clearing byte_count -> S_SEND. Other port's start is ignored, its ready stays 1. Idle counter increments each cycle in S_LOCKED; at TIMEOUT_CYCLES (if nonzero): owner cleared, csn=1, timeout_out pulse -> S_IDLE.
- S_SEND: sr_start_out=1; on sr_ready_in=0 -> S_WAIT.
- S_WAIT: on sr_ready_in=1: byte_count+1, owner's ready=1; if latched last -> owner cleared, csn=1, RR pointer=owner, S_IDLE; else -> S_LOCKED, idle counter=0.
- byte_count_out saturates at all-ones; holds after burst end until next burst accept.
- Requester contract: wait ready=1, assert start, wait ready=0, wait ready=1, drop or reassert start.

## Timing
- Accept at edge T (start and sr_ready_in sampled 1): from T+1 sr_start_out=1, reqN_ready_out=0, outputs sr_byte/dc valid, csn low.
- sr_start_out falls the cycle after sr_ready_in=0 is sampled.
- reqN_ready_out rises the cycle after sr_ready_in=1 is sampled in S_WAIT; earliest next accept one edge later (min 2-cycle gap between bytes at arbiter).
- Simultaneous start in S_IDLE: one winner only; loser sees ready=1 throughout and is accepted in the S_IDLE following burst end.
- Start arriving same edge as timeout: timeout wins; request re-arbitrated in S_IDLE.
- Owner start in S_LOCKED on the timeout-limit cycle counts as accept (accept checked first, counter cleared).
- resetn_in low mid-byte: all outputs to reset values asynchronously; in-flight byte abandoned.

## Test plan
- Single burst port 0 bytes 0xAE,0xD5,0x80(last), dc=0 -> three sr_start pulses, sr_byte in order, csn low from first accept to cycle after third completion, byte_count_out=3, grant_out=01 then 00.
- Both ports request same cycle, RR_MODE=0 -> port 0 burst completes fully before port 1 first byte; port 1 ready stays 1 until its accept.
- RR_MODE=1, both ports request continuously with 1-byte bursts -> grants alternate 01,10,01,10; first grant port 0.
- Port 1 sends one non-last byte (dc=1, 0x55) then stalls, TIMEOUT_CYCLES=8 -> timeout_out pulse exactly 8 cycles after S_LOCKED entry, csn=1, pending port 0 then granted.
- Assert resetn_in low while sr_start_out=1 -> same cycle sr_start_out=0, csn=1, ready=1, grant 0; after release, fresh request served normally.
- Port 1 request while port 0 locked between bytes -> no port 1 byte appears on sr_byte_out until port 0 last byte completes.

Source files
------------

// File: rtl/ssd1306_spi_arbiter.sv
// Two-port burst arbiter in front of the SSD1306 SPI byte shifter.
// Owns chip-select and D/C; a stalled owner is released after an idle timeout.
module ssd1306_spi_arbiter #(
    parameter int RR_MODE        = 0,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk_in,
    input  logic                 resetn_in,
    input  logic                 req0_start_in,
    input  logic [7:0]           req0_byte_in,
    input  logic                 req0_last_in,
    input  logic                 req0_dc_in,
    output logic                 req0_ready_out,
    input  logic                 req1_start_in,
    input  logic [7:0]           req1_byte_in,
    input  logic                 req1_last_in,
    input  logic                 req1_dc_in,
    output logic                 req1_ready_out,
    output logic                 sr_start_out,
    output logic [7:0]           sr_byte_out,
    input  logic                 sr_ready_in,
    output logic                 oled_dc_out,
    output logic                 oled_csn_out,
    output logic [1:0]           grant_out,
    output logic                 busy_out,
    output logic                 timeout_out,
    output logic [CNT_WIDTH-1:0] byte_count_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOCKED,
        S_SEND,
        S_WAIT
    } state_e;

    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [1:0]           own_q, own_d;
    logic [1:0]           rdy_q, rdy_d;
    logic [7:0]           byte_q, byte_d;
    logic                 dc_q, dc_d;
    logic                 last_q, last_d;
    logic                 csn_q, csn_d;
    logic                 to_q, to_d;
    logic                 rrl_q, rrl_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          idle_q, idle_d;

    logic [1:0] starts;
    logic [1:0] win;
    logic       acc;
    logic [1:0] acc_sel;

    assign starts = {req1_start_in, req0_start_in};

    // rrl_q set means port 1 was granted last, so port 0 wins a tie
    always_comb begin
        win = 2'b00;
        if (&starts) begin
            win = (RR_MODE != 0 && !rrl_q) ? 2'b10 : 2'b01;
        end else if (starts[0]) begin
            win = 2'b01;
        end else if (starts[1]) begin
            win = 2'b10;
        end
    end

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        rdy_d   = rdy_q;
        byte_d  = byte_q;
        dc_d    = dc_q;
        last_d  = last_q;
        csn_d   = csn_q;
        to_d    = 1'b0;
        rrl_d   = rrl_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        acc     = 1'b0;
        acc_sel = 2'b00;
        unique case (state_q)
            S_IDLE: begin
                if (sr_ready_in && |win) begin
                    acc     = 1'b1;
                    acc_sel = win;
                    cnt_d   = '0;
                    csn_d   = 1'b0;
                end
            end
            S_LOCKED: begin
                if (sr_ready_in && |(own_q & starts)) begin
                    acc     = 1'b1;
                    acc_sel = own_q;
                    idle_d  = '0;
                end else if (TIMEOUT_CYCLES != 0 && idle_q == TO_LIM) begin
                    own_d   = 2'b00;
                    csn_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_q + 32'd1;
                end
            end
            S_SEND: begin
                if (!sr_ready_in) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sr_ready_in) begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    rdy_d = rdy_q | own_q;
                    if (last_q) begin
                        own_d   = 2'b00;
                        csn_d   = 1'b1;
                        rrl_d   = own_q[1];
                        state_d = S_IDLE;
                    end else begin
                        idle_d  = '0;
                        state_d = S_LOCKED;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (acc) begin
            own_d   = acc_sel;
            byte_d  = acc_sel[1] ? req1_byte_in : req0_byte_in;
            dc_d    = acc_sel[1] ? req1_dc_in : req0_dc_in;
            last_d  = acc_sel[1] ? req1_last_in : req0_last_in;
            rdy_d   = rdy_q & ~acc_sel;
            state_d = S_SEND;
        end
    end

    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            state_q <= S_IDLE;
            own_q   <= 2'b00;
            rdy_q   <= 2'b11;
            byte_q  <= 8'h00;
            dc_q    <= 1'b0;
            last_q  <= 1'b0;
            csn_q   <= 1'b1;
            to_q    <= 1'b0;
            rrl_q   <= 1'b1;
            cnt_q   <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            rdy_q   <= rdy_d;
            byte_q  <= byte_d;
            dc_q    <= dc_d;
            last_q  <= last_d;
            csn_q   <= csn_d;
            to_q    <= to_d;
            rrl_q   <= rrl_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
        end
    end

    assign req0_ready_out = rdy_q[0];
    assign req1_ready_out = rdy_q[1];
    assign sr_start_out   = (state_q == S_SEND);
    assign sr_byte_out    = byte_q;
    assign oled_dc_out    = dc_q;
    assign oled_csn_out   = csn_q;
    assign grant_out      = own_q;
    assign busy_out       = (state_q != S_IDLE);
    assign timeout_out    = to_q;
    assign byte_count_out = cnt_q;

endmodule

// File: tb/tb_ssd1306_spi_arbiter.sv
// Directed bench: instance A fixed priority, instance B round-robin with a
// 2-bit byte counter; each has a small shift-register responder.
module tb_ssd1306_spi_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       st  [2][2];
    logic       lst [2][2];
    logic       dci [2][2];
    logic [7:0] bt  [2][2];

    logic       a_rdy0, a_rdy1, a_srs, a_srr, a_dc, a_csn, a_busy, a_to;
    logic [7:0] a_srb;
    logic [1:0] a_gnt;
    logic [15:0] a_cnt;
    logic       b_rdy0, b_rdy1, b_srs, b_srr, b_dc, b_csn, b_busy, b_to;
    logic [7:0] b_srb;
    logic [1:0] b_gnt;
    logic [1:0] b_cnt;

    logic [9:0] a_log[$];
    logic [9:0] b_log[$];
    int a_dly, b_dly;

    ssd1306_spi_arbiter #(.RR_MODE(0), .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) u_a (
        .clk_in(clk), .resetn_in(rst_n),
        .req0_start_in(st[0][0]), .req0_byte_in(bt[0][0]),
        .req0_last_in(lst[0][0]), .req0_dc_in(dci[0][0]),
        .req0_ready_out(a_rdy0),
        .req1_start_in(st[0][1]), .req1_byte_in(bt[0][1]),
        .req1_last_in(lst[0][1]), .req1_dc_in(dci[0][1]),
        .req1_ready_out(a_rdy1),
        .sr_start_out(a_srs), .sr_byte_out(a_srb), .sr_ready_in(a_srr),
        .oled_dc_out(a_dc), .oled_csn_out(a_csn), .grant_out(a_gnt),
        .busy_out(a_busy), .timeout_out(a_to), .byte_count_out(a_cnt)
    );

    ssd1306_spi_arbiter #(.RR_MODE(1), .TIMEOUT_CYCLES(8), .CNT_WIDTH(2)) u_b (
        .clk_in(clk), .resetn_in(rst_n),
        .req0_start_in(st[1][0]), .req0_byte_in(bt[1][0]),
        .req0_last_in(lst[1][0]), .req0_dc_in(dci[1][0]),
        .req0_ready_out(b_rdy0),
        .req1_start_in(st[1][1]), .req1_byte_in(bt[1][1]),
        .req1_last_in(lst[1][1]), .req1_dc_in(dci[1][1]),
        .req1_ready_out(b_rdy1),
        .sr_start_out(b_srs), .sr_byte_out(b_srb), .sr_ready_in(b_srr),
        .oled_dc_out(b_dc), .oled_csn_out(b_csn), .grant_out(b_gnt),
        .busy_out(b_busy), .timeout_out(b_to), .byte_count_out(b_cnt)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_srr <= 1'b1;
            a_dly <= 0;
        end else if (a_srr && a_srs) begin
            a_srr <= 1'b0;
            a_dly <= 2;
        end else if (!a_srr) begin
            if (a_dly == 0) a_srr <= 1'b1;
            else a_dly <= a_dly - 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_srr <= 1'b1;
            b_dly <= 0;
        end else if (b_srr && b_srs) begin
            b_srr <= 1'b0;
            b_dly <= 2;
        end else if (!b_srr) begin
            if (b_dly == 0) b_srr <= 1'b1;
            else b_dly <= b_dly - 1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && a_srr && a_srs) a_log.push_back({a_gnt, a_dc, a_srb});
        if (rst_n && b_srr && b_srs) b_log.push_back({b_gnt, b_dc, b_srb});
    end

    function automatic logic rdy(input int i, input int p);
        if (i == 0) return (p == 0) ? a_rdy0 : a_rdy1;
        return (p == 0) ? b_rdy0 : b_rdy1;
    endfunction

    task automatic send_byte(input int i, input int p, input logic [7:0] b,
                             input logic d, input logic l);
        int n;
        bit expired;
        expired = 0;
        n = 0;
        while (!rdy(i, p) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) expired = 1;
        st[i][p] = 1'b1;
        bt[i][p] = b;
        dci[i][p] = d;
        lst[i][p] = l;
        @(negedge clk);
        n = 0;
        while (rdy(i, p) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) expired = 1;
        st[i][p] = 1'b0;
        n = 0;
        while (!rdy(i, p) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) expired = 1;
        checks++;
        if (expired) begin
            errors++;
            $display("FAIL handshake inst%0d port%0d byte %h: wait expired", i, p, b);
        end
    endtask

    task automatic chk_log(input string nm, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++) begin
                st[i][p] = 0; lst[i][p] = 0; dci[i][p] = 0; bt[i][p] = 0;
            end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_rdy0, a_rdy1, a_srs, a_srb, a_dc, a_csn, a_gnt, a_busy, a_to, a_cnt}
            !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_a: rdy %b%b srs %b byte %h dc %b csn %b gnt %b busy %b to %b cnt %0d",
                     a_rdy0, a_rdy1, a_srs, a_srb, a_dc, a_csn, a_gnt, a_busy, a_to, a_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({b_rdy0, b_rdy1, b_srs, b_csn, b_gnt, b_busy, b_cnt}
            !== {1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_b: rdy %b%b srs %b csn %b gnt %b busy %b cnt %0d",
                     b_rdy0, b_rdy1, b_srs, b_csn, b_gnt, b_busy, b_cnt);
        end
    endtask

    task automatic test_single_burst();
        int base;
        base = a_log.size();
        send_byte(0, 0, 8'hAE, 1'b0, 1'b0);
        checks++;
        if ({a_csn, a_gnt, a_cnt} !== {1'b0, 2'b01, 16'd1}) begin
            errors++;
            $display("FAIL burst_mid1: csn %b gnt %b cnt %0d want 0 01 1", a_csn, a_gnt, a_cnt);
        end
        send_byte(0, 0, 8'hD5, 1'b0, 1'b0);
        checks++;
        if ({a_csn, a_gnt, a_busy} !== {1'b0, 2'b01, 1'b1}) begin
            errors++;
            $display("FAIL burst_mid2: csn %b gnt %b busy %b want 0 01 1", a_csn, a_gnt, a_busy);
        end
        send_byte(0, 0, 8'h80, 1'b0, 1'b1);
        checks++;
        if ({a_csn, a_gnt, a_busy, a_cnt} !== {1'b1, 2'b00, 1'b0, 16'd3}) begin
            errors++;
            $display("FAIL burst_end: csn %b gnt %b busy %b cnt %0d want 1 00 0 3",
                     a_csn, a_gnt, a_busy, a_cnt);
        end
        checks++;
        if (a_log.size() !== base + 3) begin
            errors++;
            $display("FAIL burst_count: got %0d bytes want 3", a_log.size() - base);
        end else begin
            chk_log("burst_b0", a_log[base],     {2'b01, 1'b0, 8'hAE});
            chk_log("burst_b1", a_log[base + 1], {2'b01, 1'b0, 8'hD5});
            chk_log("burst_b2", a_log[base + 2], {2'b01, 1'b0, 8'h80});
        end
    endtask

    task automatic test_fixed_priority();
        int base, viol, n;
        bit p0done;
        base = a_log.size();
        viol = 0;
        p0done = 0;
        fork
            begin
                send_byte(0, 0, 8'h11, 1'b0, 1'b0);
                send_byte(0, 0, 8'h12, 1'b0, 1'b1);
                p0done = 1;
            end
            send_byte(0, 1, 8'h21, 1'b1, 1'b1);
            begin
                n = 0;
                while (!p0done && n < 500) begin
                    @(negedge clk);
                    if (!a_rdy1) viol++;
                    n++;
                end
            end
        join
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL prio_loser_ready: %0d low cycles want 0", viol);
        end
        checks++;
        if (a_log.size() !== base + 3) begin
            errors++;
            $display("FAIL prio_count: got %0d want 3", a_log.size() - base);
        end else begin
            chk_log("prio_0", a_log[base],     {2'b01, 1'b0, 8'h11});
            chk_log("prio_1", a_log[base + 1], {2'b01, 1'b0, 8'h12});
            chk_log("prio_2", a_log[base + 2], {2'b10, 1'b1, 8'h21});
        end
    endtask

    task automatic test_round_robin();
        int base;
        base = b_log.size();
        fork
            begin
                send_byte(1, 0, 8'hA1, 1'b0, 1'b1);
                send_byte(1, 0, 8'hA2, 1'b0, 1'b1);
            end
            begin
                send_byte(1, 1, 8'hB1, 1'b1, 1'b1);
                send_byte(1, 1, 8'hB2, 1'b1, 1'b1);
            end
        join
        checks++;
        if (b_log.size() !== base + 4) begin
            errors++;
            $display("FAIL rr_count: got %0d want 4", b_log.size() - base);
        end else begin
            chk_log("rr_0", b_log[base],     {2'b01, 1'b0, 8'hA1});
            chk_log("rr_1", b_log[base + 1], {2'b10, 1'b1, 8'hB1});
            chk_log("rr_2", b_log[base + 2], {2'b01, 1'b0, 8'hA2});
            chk_log("rr_3", b_log[base + 3], {2'b10, 1'b1, 8'hB2});
        end
    endtask

    task automatic test_saturate();
        send_byte(1, 0, 8'h01, 1'b0, 1'b0);
        send_byte(1, 0, 8'h02, 1'b0, 1'b0);
        send_byte(1, 0, 8'h03, 1'b0, 1'b0);
        checks++;
        if (b_cnt !== 2'd3) begin
            errors++;
            $display("FAIL sat_3: cnt %0d want 3", b_cnt);
        end
        send_byte(1, 0, 8'h04, 1'b0, 1'b1);
        checks++;
        if (b_cnt !== 2'd3) begin
            errors++;
            $display("FAIL sat_hold: cnt %0d want 3", b_cnt);
        end
    endtask

    task automatic test_timeout();
        int base, first, hits;
        logic [1:0] gnt7, gnt8;
        logic csn8;
        base = a_log.size();
        first = -1;
        hits = 0;
        gnt7 = 2'bxx;
        gnt8 = 2'bxx;
        csn8 = 1'bx;
        send_byte(0, 1, 8'h55, 1'b1, 1'b0);
        fork
            send_byte(0, 0, 8'h66, 1'b0, 1'b1);
            begin
                for (int k = 1; k <= 12; k++) begin
                    @(negedge clk);
                    if (a_to) begin
                        hits++;
                        if (first < 0) first = k;
                    end
                    if (k == 7) gnt7 = a_gnt;
                    if (k == 8) begin gnt8 = a_gnt; csn8 = a_csn; end
                end
            end
        join
        checks++;
        if (first !== 8 || hits !== 1) begin
            errors++;
            $display("FAIL timeout_pulse: at cycle %0d x%0d want cycle 8 x1", first, hits);
        end
        checks++;
        if ({gnt7, gnt8, csn8} !== {2'b10, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL timeout_release: gnt7 %b gnt8 %b csn8 %b want 10 00 1", gnt7, gnt8, csn8);
        end
        checks++;
        if (a_log.size() !== base + 2) begin
            errors++;
            $display("FAIL timeout_count: got %0d want 2", a_log.size() - base);
        end else begin
            chk_log("timeout_p1", a_log[base],     {2'b10, 1'b1, 8'h55});
            chk_log("timeout_p0", a_log[base + 1], {2'b01, 1'b0, 8'h66});
        end
        checks++;
        if (a_cnt !== 16'd1) begin
            errors++;
            $display("FAIL timeout_cnt: cnt %0d want 1", a_cnt);
        end
    endtask

    task automatic test_locked();
        int base, viol, n;
        bit p0done;
        base = a_log.size();
        viol = 0;
        p0done = 0;
        fork
            begin
                send_byte(0, 0, 8'h31, 1'b0, 1'b0);
                repeat (4) @(negedge clk);
                send_byte(0, 0, 8'h32, 1'b0, 1'b1);
                p0done = 1;
            end
            begin
                @(negedge clk);
                send_byte(0, 1, 8'h41, 1'b1, 1'b1);
            end
            begin
                n = 0;
                while (!p0done && n < 500) begin
                    @(negedge clk);
                    if (!a_rdy1) viol++;
                    n++;
                end
            end
        join
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL locked_other_ready: %0d low cycles want 0", viol);
        end
        checks++;
        if (a_log.size() !== base + 3) begin
            errors++;
            $display("FAIL locked_count: got %0d want 3", a_log.size() - base);
        end else begin
            chk_log("locked_0", a_log[base],     {2'b01, 1'b0, 8'h31});
            chk_log("locked_1", a_log[base + 1], {2'b01, 1'b0, 8'h32});
            chk_log("locked_2", a_log[base + 2], {2'b10, 1'b1, 8'h41});
        end
    endtask

    task automatic test_reset_mid();
        int base, n;
        @(negedge clk);
        st[0][0] = 1'b1;
        bt[0][0] = 8'h77;
        dci[0][0] = 1'b0;
        lst[0][0] = 1'b1;
        n = 0;
        while (!a_srs && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!a_srs) begin
            errors++;
            $display("FAIL rstmid_start: sr_start %b want 1", a_srs);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_srs, a_csn, a_rdy0, a_gnt, a_busy} !== {1'b0, 1'b1, 1'b1, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_async: srs %b csn %b rdy0 %b gnt %b busy %b want 0 1 1 00 0",
                     a_srs, a_csn, a_rdy0, a_gnt, a_busy);
        end
        st[0][0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = a_log.size();
        send_byte(0, 0, 8'h78, 1'b1, 1'b1);
        checks++;
        if (a_log.size() !== base + 1) begin
            errors++;
            $display("FAIL rstmid_count: got %0d want 1", a_log.size() - base);
        end else begin
            chk_log("rstmid_byte", a_log[base], {2'b01, 1'b1, 8'h78});
        end
        checks++;
        if (a_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_cnt: cnt %0d want 1", a_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_fixed_priority();
        test_round_robin();
        test_saturate();
        test_timeout();
        test_locked();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
